// File: rtl/nes_pulse_noise_core.sv
// NES APU pulse + noise voice core: length counters, envelopes, pulse sequencer
// and 15-bit noise LFSR sharing one programmable frame-tick divider.
module nes_pulse_noise_core #(
   parameter int unsigned FRAME_DIV = 29830
) (
   input  logic       i_clk,
   input  logic       i_reset,
   input  logic [7:0] i_sq_r0,
   input  logic [7:0] i_sq_r1,
   input  logic [7:0] i_sq_r2,
   input  logic [7:0] i_sq_r3,
   input  logic       i_sq_r3_wr,
   input  logic [7:0] i_noise_r0,
   input  logic [7:0] i_noise_r2,
   input  logic [7:0] i_noise_r3,
   input  logic       i_noise_r3_wr,
   input  logic       i_sq_en,
   input  logic       i_noise_en,
   output logic [3:0] o_sq_out,
   output logic [3:0] o_noise_out,
   output logic       o_sq_active,
   output logic       o_noise_active,
   output logic       o_frame_tick
);

   localparam logic [15:0] LP_TICK_AT = 16'(FRAME_DIV - 1);

   function automatic logic [7:0] len_lut(input logic [4:0] idx);
      logic [7:0] v;
      case (idx)
         5'd0:  v = 8'd10;   5'd1:  v = 8'd254; 5'd2:  v = 8'd20;  5'd3:  v = 8'd2;
         5'd4:  v = 8'd40;   5'd5:  v = 8'd4;   5'd6:  v = 8'd80;  5'd7:  v = 8'd6;
         5'd8:  v = 8'd160;  5'd9:  v = 8'd8;   5'd10: v = 8'd60;  5'd11: v = 8'd10;
         5'd12: v = 8'd14;   5'd13: v = 8'd12;  5'd14: v = 8'd26;  5'd15: v = 8'd14;
         5'd16: v = 8'd12;   5'd17: v = 8'd16;  5'd18: v = 8'd24;  5'd19: v = 8'd18;
         5'd20: v = 8'd48;   5'd21: v = 8'd20;  5'd22: v = 8'd96;  5'd23: v = 8'd22;
         5'd24: v = 8'd192;  5'd25: v = 8'd24;  5'd26: v = 8'd72;  5'd27: v = 8'd26;
         5'd28: v = 8'd16;   5'd29: v = 8'd28;  5'd30: v = 8'd32;  default: v = 8'd30;
      endcase
      return v;
   endfunction

   function automatic logic [11:0] noise_lut(input logic [3:0] idx);
      logic [11:0] v;
      case (idx)
         4'd0:  v = 12'd4;    4'd1:  v = 12'd8;    4'd2:  v = 12'd16;   4'd3:  v = 12'd32;
         4'd4:  v = 12'd64;   4'd5:  v = 12'd96;   4'd6:  v = 12'd128;  4'd7:  v = 12'd160;
         4'd8:  v = 12'd202;  4'd9:  v = 12'd254;  4'd10: v = 12'd380;  4'd11: v = 12'd508;
         4'd12: v = 12'd762;  4'd13: v = 12'd1016; 4'd14: v = 12'd2034; default: v = 12'd4068;
      endcase
      return v;
   endfunction

   // Sweep register and several don't-care bits are accepted but have no effect.
   logic w_unused;
   assign w_unused = ^{i_sq_r1, i_noise_r2[6:4], i_noise_r3[2:0]};

   // ---------------- frame divider ----------------
   logic [15:0] r_cnt;
   logic        w_frame_tick;

   assign w_frame_tick = (r_cnt == LP_TICK_AT);
   assign o_frame_tick = w_frame_tick;

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset)           r_cnt <= 16'd0;
      else if (w_frame_tick) r_cnt <= 16'd0;
      else                   r_cnt <= r_cnt + 16'd1;
   end

   // ---------------- per-channel length + envelope (0 = pulse, 1 = noise) ----------------
   logic [1:0][7:0] w_r0;
   logic [1:0][7:0] w_r3;
   logic [1:0]      w_wr;
   logic [1:0]      w_en;
   logic [1:0][7:0] w_len;
   logic [1:0][3:0] w_vol;

   assign w_r0 = {i_noise_r0, i_sq_r0};
   assign w_r3 = {i_noise_r3, i_sq_r3};
   assign w_wr = {i_noise_r3_wr, i_sq_r3_wr};
   assign w_en = {i_noise_en, i_sq_en};

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : gen_ch
         logic [7:0] r_len;
         logic [3:0] r_env_div;
         logic [3:0] r_decay;
         logic       r_start;

         always_ff @(posedge i_clk or posedge i_reset) begin
            if (i_reset) begin
               r_len     <= 8'd0;
               r_env_div <= 4'd0;
               r_decay   <= 4'd0;
               r_start   <= 1'b0;
            end else begin
               if (!w_en[gi])
                  r_len <= 8'd0;
               else if (w_wr[gi])
                  r_len <= len_lut(w_r3[gi][7:3]);
               else if (w_frame_tick && !w_r0[gi][5] && (r_len != 8'd0))
                  r_len <= r_len - 8'd1;

               // A write coinciding with a tick only arms start; the restart waits a tick.
               if (w_wr[gi]) begin
                  r_start <= 1'b1;
               end else if (w_frame_tick) begin
                  if (r_start) begin
                     r_start   <= 1'b0;
                     r_decay   <= 4'hF;
                     r_env_div <= w_r0[gi][3:0];
                  end else if (r_env_div == 4'd0) begin
                     r_env_div <= w_r0[gi][3:0];
                     if (r_decay != 4'd0)   r_decay <= r_decay - 4'd1;
                     else if (w_r0[gi][5])  r_decay <= 4'hF;
                  end else begin
                     r_env_div <= r_env_div - 4'd1;
                  end
               end
            end
         end

         assign w_len[gi] = r_len;
         assign w_vol[gi] = w_r0[gi][4] ? w_r0[gi][3:0] : r_decay;
      end
   endgenerate

   assign o_sq_active    = (w_len[0] != 8'd0);
   assign o_noise_active = (w_len[1] != 8'd0);

   // ---------------- pulse channel ----------------
   logic [10:0] w_period;
   logic [10:0] r_sq_timer;
   logic [2:0]  r_step;
   logic        r_half;
   logic [7:0]  w_duty_pat;
   logic        w_duty_bit;

   assign w_period = {i_sq_r3[2:0], i_sq_r2};

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_half     <= 1'b0;
         r_sq_timer <= 11'd0;
         r_step     <= 3'd0;
      end else begin
         r_half <= ~r_half;
         if (r_half) begin
            if (r_sq_timer == 11'd0) begin
               r_sq_timer <= w_period;
               r_step     <= r_step + 3'd1;
            end else begin
               r_sq_timer <= r_sq_timer - 11'd1;
            end
         end
         if (i_sq_r3_wr) r_step <= 3'd0;
      end
   end

   // Patterns are written step 0 in the MSB.
   always_comb begin
      w_duty_pat = 8'b0100_0000;
      case (i_sq_r0[7:6])
         2'b00:   w_duty_pat = 8'b0100_0000;
         2'b01:   w_duty_pat = 8'b0110_0000;
         2'b10:   w_duty_pat = 8'b0111_1000;
         default: w_duty_pat = 8'b1001_1111;
      endcase
   end

   assign w_duty_bit = w_duty_pat[3'd7 - r_step];
   assign o_sq_out   = (w_duty_bit && (w_len[0] != 8'd0) && (w_period >= 11'd8)) ? w_vol[0] : 4'd0;

   // ---------------- noise channel ----------------
   logic [11:0] r_noise_timer;
   logic [11:0] w_noise_reload;
   logic [14:0] r_lfsr;
   logic        w_fb;

   assign w_noise_reload = noise_lut(i_noise_r2[3:0]) - 12'd1;
   assign w_fb           = r_lfsr[0] ^ (i_noise_r2[7] ? r_lfsr[6] : r_lfsr[1]);

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_noise_timer <= 12'd0;
         r_lfsr        <= 15'd1;
      end else if (r_noise_timer == 12'd0) begin
         r_noise_timer <= w_noise_reload;
         r_lfsr        <= {w_fb, r_lfsr[14:1]};
      end else begin
         r_noise_timer <= r_noise_timer - 12'd1;
      end
   end

   assign o_noise_out = (!r_lfsr[0] && (w_len[1] != 8'd0)) ? w_vol[1] : 4'd0;

endmodule

// File: tb/tb_nes_pulse_noise_core.sv
// Directed bench for nes_pulse_noise_core with FRAME_DIV=16; k counts rising edges
// since reset release and all sampling happens on the falling edge.
module tb_nes_pulse_noise_core;
   logic       clk = 1'b0;
   logic       i_reset;
   logic [7:0] i_sq_r0, i_sq_r1, i_sq_r2, i_sq_r3;
   logic       i_sq_r3_wr;
   logic [7:0] i_noise_r0, i_noise_r2, i_noise_r3;
   logic       i_noise_r3_wr;
   logic       i_sq_en, i_noise_en;
   logic [3:0] o_sq_out, o_noise_out;
   logic       o_sq_active, o_noise_active, o_frame_tick;

   always #5 clk = ~clk;

   nes_pulse_noise_core #(.FRAME_DIV(16)) dut (
      .i_clk(clk), .i_reset(i_reset),
      .i_sq_r0(i_sq_r0), .i_sq_r1(i_sq_r1), .i_sq_r2(i_sq_r2), .i_sq_r3(i_sq_r3),
      .i_sq_r3_wr(i_sq_r3_wr),
      .i_noise_r0(i_noise_r0), .i_noise_r2(i_noise_r2), .i_noise_r3(i_noise_r3),
      .i_noise_r3_wr(i_noise_r3_wr),
      .i_sq_en(i_sq_en), .i_noise_en(i_noise_en),
      .o_sq_out(o_sq_out), .o_noise_out(o_noise_out),
      .o_sq_active(o_sq_active), .o_noise_active(o_noise_active),
      .o_frame_tick(o_frame_tick)
   );

   int          checks = 0;
   int          errors = 0;
   int          kk = 0;
   int          n;
   logic [14:0] m = 15'd1;   // reference LFSR
   logic        nmode = 1'b0;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s k=%0d observed=%0h expected=%0h", tag, kk, obs, exp);
      end
   endtask

   // Noise period 4: LFSR clocks on the edges ending cycles 0,4,8,... i.e. at k = 1,5,9,...
   task automatic goto(input int t);
      while (kk < t) begin
         @(negedge clk);
         kk++;
         if (kk % 4 == 1) m = {m[0] ^ (nmode ? m[6] : m[1]), m[14:1]};
      end
   endtask

   function automatic logic [3:0] nexp(input logic [3:0] vol);
      return m[0] ? 4'd0 : vol;
   endfunction

   task automatic do_reset;
      @(negedge clk);
      i_reset = 1'b1;
      @(negedge clk);
      i_reset = 1'b0;
      kk = 0;
      m  = 15'd1;
   endtask

   task automatic wait_tick(output int cnt);
      cnt = 0;
      do begin
         @(negedge clk);
         cnt++;
         kk++;
      end while (!o_frame_tick && cnt < 200);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog k=%0d", kk);
      $fatal(1);
   end

   initial begin
      i_reset = 1'b1;
      {i_sq_r0, i_sq_r1, i_sq_r2, i_sq_r3, i_noise_r0, i_noise_r2, i_noise_r3} = '0;
      {i_sq_r3_wr, i_noise_r3_wr, i_sq_en, i_noise_en} = '0;
      repeat (2) @(negedge clk);
      i_reset = 1'b0;
      kk = 0;

      // Reset / idle
      chk("rst_sq_out", 16'(o_sq_out), 16'd0);
      chk("rst_noise_out", 16'(o_noise_out), 16'd0);
      chk("rst_sq_active", 16'(o_sq_active), 16'd0);
      chk("rst_noise_active", 16'(o_noise_active), 16'd0);
      chk("rst_tick", 16'(o_frame_tick), 16'd0);
      goto(15);
      chk("tick_k15", 16'(o_frame_tick), 16'd1);
      #2 i_reset = 1'b1;
      #1 chk("async_rst_tick", 16'(o_frame_tick), 16'd0);
      @(negedge clk);
      i_reset = 1'b0;
      kk = 0;
      wait_tick(n);
      chk("first_tick_dist", 16'(n), 16'd15);
      wait_tick(n);
      chk("tick_period", 16'(n), 16'd16);
      chk("idle_sq_out", 16'(o_sq_out), 16'd0);

      // Constant-volume pulse, duty 10, P=8: step edges at k = 2, 20, 38, ...
      i_sq_r0 = 8'hB7; i_sq_r2 = 8'd8; i_sq_r3 = 8'h08; i_sq_en = 1'b1;
      do_reset;
      i_sq_r3_wr = 1'b1;
      goto(1);
      i_sq_r3_wr = 1'b0;
      chk("sq_step0", 16'(o_sq_out), 16'd0);
      chk("sq_active", 16'(o_sq_active), 16'd1);
      goto(2);   chk("sq_step1", 16'(o_sq_out), 16'd7);
      goto(73);  chk("sq_step4_end", 16'(o_sq_out), 16'd7);
      goto(74);  chk("sq_step5", 16'(o_sq_out), 16'd0);
      goto(145); chk("sq_step0_end", 16'(o_sq_out), 16'd0);
      goto(146); chk("sq_step1_again", 16'(o_sq_out), 16'd7);
      i_sq_r2 = 8'd7;
      goto(150); chk("sq_p7_mute", 16'(o_sq_out), 16'd0);
      goto(200); chk("sq_p7_mute2", 16'(o_sq_out), 16'd0);

      // Length expiry: index 3 -> 2, ticks update at k = 16, 32
      i_sq_r0 = 8'h1F; i_sq_r2 = 8'd8; i_sq_r3 = 8'h18;
      do_reset;
      i_sq_r3_wr = 1'b1;
      goto(1);
      i_sq_r3_wr = 1'b0;
      chk("len_loaded", 16'(o_sq_active), 16'd1);
      goto(31); chk("len_before_2nd", 16'(o_sq_active), 16'd1);
      goto(32); chk("len_expired", 16'(o_sq_active), 16'd0);
      goto(48); chk("len_no_wrap", 16'(o_sq_active), 16'd0);
      i_sq_r0 = 8'h3F;
      do_reset;
      i_sq_r3_wr = 1'b1;
      goto(1);
      i_sq_r3_wr = 1'b0;
      goto(40); chk("len_halt", 16'(o_sq_active), 16'd1);
      i_sq_en = 1'b0;
      goto(41); chk("len_disable", 16'(o_sq_active), 16'd0);
      i_sq_r3_wr = 1'b1;
      goto(42);
      i_sq_r3_wr = 1'b0;
      chk("len_wr_ignored", 16'(o_sq_active), 16'd0);

      // Envelope decay on noise, period 0: decay 15-j at k = 16+16j
      i_noise_r0 = 8'h00; i_noise_r2 = 8'h00; i_noise_r3 = 8'h08; i_noise_en = 1'b1; nmode = 1'b0;
      do_reset;
      i_noise_r3_wr = 1'b1;
      goto(1);
      i_noise_r3_wr = 1'b0;
      chk("noise_active", 16'(o_noise_active), 16'd1);
      goto(15); chk("env_pre_start", 16'(o_noise_out), 16'd0);
      for (int j = 0; j <= 16; j++) begin
         goto(16 + 16 * j);
         chk("env_decay", 16'(o_noise_out), 16'(nexp((j <= 15) ? 4'(15 - j) : 4'd0)));
      end

      // Envelope loop: decay 0 at k=256 wraps to 15 at k=272
      i_noise_r0 = 8'h20;
      do_reset;
      i_noise_r3_wr = 1'b1;
      goto(1);
      i_noise_r3_wr = 1'b0;
      goto(256); chk("env_loop_zero", 16'(o_noise_out), 16'(nexp(4'd0)));
      for (int k = 272; k < 288; k++) begin
         goto(k);
         chk("env_loop_wrap", 16'(o_noise_out), 16'(nexp(4'd15)));
      end
      goto(288); chk("env_loop_14", 16'(o_noise_out), 16'(nexp(4'd14)));

      // LFSR long mode then short mode against the reference model
      i_noise_r0 = 8'h3F;
      do_reset;
      i_noise_r3_wr = 1'b1;
      goto(1);
      i_noise_r3_wr = 1'b0;
      for (int k = 1; k <= 400; k++) begin
         goto(k);
         chk("lfsr_long", 16'(o_noise_out), 16'(nexp(4'd15)));
      end
      i_noise_r2 = 8'h80; nmode = 1'b1;
      do_reset;
      i_noise_r3_wr = 1'b1;
      goto(1);
      i_noise_r3_wr = 1'b0;
      for (int k = 1; k <= 400; k++) begin
         goto(k);
         chk("lfsr_short", 16'(o_noise_out), 16'(nexp(4'd15)));
      end

      // Collision: write during tick cycle 15 -> length 2 survives until k=48
      i_noise_r0 = 8'h00; i_noise_r2 = 8'h00; i_noise_r3 = 8'h18; nmode = 1'b0;
      do_reset;
      goto(14); chk("col_pre", 16'(o_noise_active), 16'd0);
      goto(15); chk("col_tick", 16'(o_frame_tick), 16'd1);
      i_noise_r3_wr = 1'b1;
      goto(16);
      i_noise_r3_wr = 1'b0;
      chk("col_loaded", 16'(o_noise_active), 16'd1);
      for (int k = 16; k < 32; k++) begin
         goto(k);
         chk("col_env_deferred", 16'(o_noise_out), 16'd0);
      end
      for (int k = 32; k < 48; k++) begin
         goto(k);
         chk("col_env_start", 16'(o_noise_out), 16'(nexp(4'd15)));
      end
      chk("col_len_k47", 16'(o_noise_active), 16'd1);
      goto(48); chk("col_len_k48", 16'(o_noise_active), 16'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/nes_pulse_noise_core.md
# nes_pulse_noise_core

NES APU pulse-plus-noise voice core: one square (pulse) channel and one noise channel sharing a programmable frame-tick divider. It takes raw APU register bytes ($4000–$4003 pulse, $400C/$400E/$400F noise, $4015 enables) and produces 4-bit channel levels for the downstream mixer. The mixer applies the nonlinear sq/tnd tables outside this block.

## Interface
- FRAME_DIV, 29830: clk cycles per frame tick; legal range 2..65535.
- clk  in  1  APU/CPU clock; all state on rising edge.
- reset  in  1  asynchronous, active-high.
- sq_r0, sq_r1, sq_r2, sq_r3  in  8 each  pulse registers $4000–$4003. sq_r1 (sweep) is accepted and ignored.
- sq_r3_wr  in  1  one-cycle strobe: $4003 written.
- noise_r0, noise_r2, noise_r3  in  8 each  $400C, $400E, $400F.
- noise_r3_wr  in  1  one-cycle strobe: $400F written.
- sq_en, noise_en  in  1  $4015 enable bits.
- sq_out  out  4  pulse level.
- noise_out  out  4  noise level.
- sq_active, noise_active  out  1  length counter ≠ 0.
- frame_tick  out  1  one-cycle frame pulse.

## Operation
- **Divider**
  - 16-bit counter 0..FRAME_DIV-1, increments every clk and wraps to 0.
  - frame_tick = (cnt == FRAME_DIV-1), combinational.
- **Register fields** (r0 = sq_r0 or noise_r0):
  - [3:0] volume / envelope period
  - [4] constant-volume
  - [5] length halt / envelope loop
  - sq_r0[7:6] duty
- **Length counters** (8-bit, one per channel)
  - On a *_r3_wr strobe with the enable high: load LEN[r3[7:3]].
  - LEN = 10,254,20,2,40,4,80,6,160,8,60,10,14,12,26,14,12,16,24,18,48,20,96,22,192,24,72,26,16,28,32,30.
  - Enable low: counter forced to 0 every cycle, and writes are ignored.
  - On frame_tick with halt = 0 and count > 0: decrement.
- **Envelopes** (one per channel; 4-bit divider, 4-bit decay)
  - A *_r3_wr strobe sets the start flag.
  - On frame_tick with start set: clear start, decay = 15, divider = r0[3:0].
  - On frame_tick otherwise: if divider == 0, reload it with r0[3:0], then decrement decay if > 0, else set decay = 15 if loop is set. If divider ≠ 0, decrement the divider.
  - Volume = r0[4] ? r0[3:0] : decay.
- **Pulse channel**
  - Period P = {sq_r3[2:0], sq_r2} (11 bits).
  - A half-rate toggle gates the timer, so the timer advances on every second clk.
  - On a gated cycle: if timer == 0, reload P and advance the 3-bit step (7 wraps to 0); else decrement the timer.
  - sq_r3_wr resets the step to 0; the timer is not affected.
  - Duty patterns, steps 0..7:
    - 00: 0100_0000
    - 01: 0110_0000
    - 10: 0111_1000
    - 11: 1001_1111
  - sq_out = volume, except 0 when the duty bit is 0, length == 0, or P < 8.
- **Noise channel**
  - Period N from NT[noise_r2[3:0]] = 4,8,16,32,64,96,128,160,202,254,380,508,762,1016,2034,4068.
  - The 12-bit timer counts N-1 down to 0 every clk. At 0 it reloads N-1 and clocks the LFSR.
  - 15-bit LFSR, reset value 1. Feedback = b0 ^ (noise_r2[7] ? b6 : b1); shift right, feedback enters b14.
  - noise_out = volume, except 0 when b0 == 1 or length == 0.
- sq_out, noise_out and *_active are combinational from registered state.

## Timing
- **Reset values:** divider cnt, timers, step, half-rate toggle, length counters, envelope dividers, decay and start flags are all 0; LFSR = 1.
  - All outputs are therefore 0 during and after reset until state changes.
- A period change takes effect at the next timer reload; the running count is not restarted.
- First frame_tick is high in cycle FRAME_DIV-1 after reset release (cycles counted from 0). Tick-driven updates land on the edge ending that cycle.
- **Simultaneous *_r3_wr and frame_tick:** the load wins (no decrement that tick), and the start flag is set. The envelope start is processed on the next tick.
- Length counter at 0 with frame_tick: stays 0, no wrap.
- Step advances every 2·(P+1) clk, giving a pulse tone period of 16·(P+1) clk. Noise clocks every N clk.

## Test plan
- **Reset and idle:** FRAME_DIV=16, reset mid-run, all inputs 0 → all outputs 0, frame_tick first high 15 cycles after release, then every 16 cycles.
- **Constant-volume pulse:** sq_r0=0xB7 (duty 10, const, vol 7), P=8, sq_en=1, write r3=0x08 (index 1 → 254) → sq_out is 7 for 4 steps then 0 for 4 steps, each step 18 clk; sq_active=1. With P=7 → sq_out stays 0.
- **Length expiry:** sq_r0=0x1F, r3 index 3 (len 2), FRAME_DIV=16 → sq_active drops after the 2nd frame_tick. Same with r0[5]=1 → never drops. Set sq_en=0 → immediate 0.
- **Envelope decay:** noise_r0=0x00, noise_r3_wr → noise_out levels follow decay 15,14,…,0 one step per frame_tick (when LFSR b0 = 0). With loop set, 0 wraps to 15.
- **LFSR:** noise_r2=0x00 (N=4), enable, length loaded → b0 sequence matches the software model from 1 (long mode). noise_r2=0x80 gives the 93-step short mode.
- **Collision:** noise_r3_wr coincident with frame_tick → length equals LEN[index] exactly, no decrement.
